// File: rtl/bp_tlb_miss_arbiter.sv
// bp_tlb_miss_arbiter
// Shares one page-table walker between the ITLB and DTLB miss paths.
// Misses are granted one at a time, round-robin on ties. The block drives
// the walk request and response handshake, then routes the fill or fault
// back to the TLB that missed. A flush kills any walk in flight and pulses
// a clear to both TLBs. Walks are counted per source with saturating counters.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no walk in flight; a miss may be granted this cycle
// S_REQ  | walk request presented to the PTW, waiting for ready
// S_WAIT | walk issued, waiting for the response (kill_r marks a flushed walk)
// S_RESP | one cycle: fill or fault driven to the originating TLB
module bp_tlb_miss_arbiter #(
  parameter int vtag_width_p  = 27,
  parameter int ptag_width_p  = 28,
  parameter int entry_width_p = 34,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,

  input  logic                     itlb_miss_v_i,
  input  logic [vtag_width_p-1:0]  itlb_miss_vtag_i,
  output logic                     itlb_miss_yumi_o,

  input  logic                     dtlb_miss_v_i,
  input  logic [vtag_width_p-1:0]  dtlb_miss_vtag_i,
  output logic                     dtlb_miss_yumi_o,

  output logic                     ptw_req_v_o,
  output logic [vtag_width_p-1:0]  ptw_req_vtag_o,
  output logic                     ptw_req_src_o,
  input  logic                     ptw_req_ready_i,

  input  logic                     ptw_resp_v_i,
  input  logic                     ptw_resp_fault_i,
  input  logic [entry_width_p-1:0] ptw_resp_entry_i,

  output logic [vtag_width_p-1:0]  fill_vtag_o,
  output logic [entry_width_p-1:0] fill_entry_o,
  output logic                     itlb_fill_v_o,
  output logic                     dtlb_fill_v_o,
  output logic                     itlb_fault_v_o,
  output logic                     dtlb_fault_v_o,
  output logic                     itlb_clear_o,
  output logic                     dtlb_clear_o,

  output logic                     busy_o,
  output logic [count_width_p-1:0] itlb_walk_count_o,
  output logic [count_width_p-1:0] dtlb_walk_count_o
);

  // The physical tag travels inside the leaf entry, so it must fit there.
  if (ptag_width_p > entry_width_p) begin : g_bad_ptag_width
    $error("ptag_width_p must not exceed entry_width_p");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e state_r, state_n;

  logic                     prio_r;
  logic                     kill_r;
  logic                     src_r;
  logic                     fault_r;
  logic                     clear_r;
  logic [vtag_width_p-1:0]  vtag_r;
  logic [entry_width_p-1:0] entry_r;
  logic [count_width_p-1:0] itlb_cnt_r;
  logic [count_width_p-1:0] dtlb_cnt_r;

  logic grant_v;
  logic grant_src;
  logic resp_accept;

  // Round-robin grant: lone requester wins, prio_r breaks a tie (0 = ITLB).
  always_comb begin
    grant_v   = (state_r == S_IDLE) && !flush_i && (itlb_miss_v_i || dtlb_miss_v_i);
    grant_src = dtlb_miss_v_i && (!itlb_miss_v_i || prio_r);
  end

  // A response is only taken in WAIT and only if the walk was not flushed.
  assign resp_accept = (state_r == S_WAIT) && ptw_resp_v_i && !kill_r && !flush_i;

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= S_IDLE;
    else            state_r <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      S_IDLE: if (grant_v) state_n = S_REQ;
      S_REQ: begin
        if (flush_i)              state_n = S_IDLE;
        else if (ptw_req_ready_i) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (ptw_resp_v_i) state_n = resp_accept ? S_RESP : S_IDLE;
      end
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs decoded from state and the latched walk context.
  always_comb begin
    itlb_miss_yumi_o = grant_v && !grant_src;
    dtlb_miss_yumi_o = grant_v &&  grant_src;
    // A flush withdraws the request in the same cycle so no walk can start.
    ptw_req_v_o      = (state_r == S_REQ) && !flush_i;
    ptw_req_vtag_o   = vtag_r;
    ptw_req_src_o    = src_r;
    itlb_fill_v_o    = (state_r == S_RESP) && !src_r && !fault_r;
    dtlb_fill_v_o    = (state_r == S_RESP) &&  src_r && !fault_r;
    itlb_fault_v_o   = (state_r == S_RESP) && !src_r &&  fault_r;
    dtlb_fault_v_o   = (state_r == S_RESP) &&  src_r &&  fault_r;
    busy_o           = (state_r != S_IDLE);
  end

  assign fill_vtag_o       = vtag_r;
  assign fill_entry_o      = entry_r;
  assign itlb_clear_o      = clear_r;
  assign dtlb_clear_o      = clear_r;
  assign itlb_walk_count_o = itlb_cnt_r;
  assign dtlb_walk_count_o = dtlb_cnt_r;

  // Grant context: vtag/src latched, priority flipped to the other source.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vtag_r <= '0;
      src_r  <= 1'b0;
      prio_r <= 1'b0;
    end else if (grant_v) begin
      vtag_r <= grant_src ? dtlb_miss_vtag_i : itlb_miss_vtag_i;
      src_r  <= grant_src;
      prio_r <= !grant_src;
    end
  end

  // Kill flag: set by a flush while waiting, cleared once the walk retires.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                                kill_r <= 1'b0;
    else if (state_n == S_IDLE)                    kill_r <= 1'b0;
    else if ((state_r == S_WAIT) && flush_i)       kill_r <= 1'b1;
  end

  // Walk result capture for the RESP cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      entry_r <= '0;
      fault_r <= 1'b0;
    end else if (resp_accept) begin
      entry_r <= ptw_resp_entry_i;
      fault_r <= ptw_resp_fault_i;
    end
  end

  // TLB clear is a one-cycle-delayed copy of the flush request.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) clear_r <= 1'b0;
    else            clear_r <= flush_i;
  end

  // Saturating per-source grant counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      itlb_cnt_r <= '0;
      dtlb_cnt_r <= '0;
    end else if (grant_v) begin
      if (!grant_src && (itlb_cnt_r != '1)) itlb_cnt_r <= itlb_cnt_r + 1'b1;
      if ( grant_src && (dtlb_cnt_r != '1)) dtlb_cnt_r <= dtlb_cnt_r + 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_tlb_miss_arbiter.sv
// Directed bench for bp_tlb_miss_arbiter; counters narrowed to 2 bits so
// saturation is reachable. Inputs change 1ns after the rising edge and
// outputs are sampled 1ns after that.
module tb_bp_tlb_miss_arbiter;

  localparam int VW = 27;
  localparam int EW = 34;
  localparam int CW = 2;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          flush_i;
  logic          itlb_miss_v_i, dtlb_miss_v_i;
  logic [VW-1:0] itlb_miss_vtag_i, dtlb_miss_vtag_i;
  logic          itlb_miss_yumi_o, dtlb_miss_yumi_o;
  logic          ptw_req_v_o, ptw_req_src_o, ptw_req_ready_i;
  logic [VW-1:0] ptw_req_vtag_o;
  logic          ptw_resp_v_i, ptw_resp_fault_i;
  logic [EW-1:0] ptw_resp_entry_i;
  logic [VW-1:0] fill_vtag_o;
  logic [EW-1:0] fill_entry_o;
  logic          itlb_fill_v_o, dtlb_fill_v_o, itlb_fault_v_o, dtlb_fault_v_o;
  logic          itlb_clear_o, dtlb_clear_o, busy_o;
  logic [CW-1:0] itlb_walk_count_o, dtlb_walk_count_o;

  int n_cmp = 0;
  int n_bad = 0;

  bp_tlb_miss_arbiter #(
    .vtag_width_p(VW), .ptag_width_p(28), .entry_width_p(EW), .count_width_p(CW)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
    .itlb_miss_v_i(itlb_miss_v_i), .itlb_miss_vtag_i(itlb_miss_vtag_i),
    .itlb_miss_yumi_o(itlb_miss_yumi_o),
    .dtlb_miss_v_i(dtlb_miss_v_i), .dtlb_miss_vtag_i(dtlb_miss_vtag_i),
    .dtlb_miss_yumi_o(dtlb_miss_yumi_o),
    .ptw_req_v_o(ptw_req_v_o), .ptw_req_vtag_o(ptw_req_vtag_o),
    .ptw_req_src_o(ptw_req_src_o), .ptw_req_ready_i(ptw_req_ready_i),
    .ptw_resp_v_i(ptw_resp_v_i), .ptw_resp_fault_i(ptw_resp_fault_i),
    .ptw_resp_entry_i(ptw_resp_entry_i),
    .fill_vtag_o(fill_vtag_o), .fill_entry_o(fill_entry_o),
    .itlb_fill_v_o(itlb_fill_v_o), .dtlb_fill_v_o(dtlb_fill_v_o),
    .itlb_fault_v_o(itlb_fault_v_o), .dtlb_fault_v_o(dtlb_fault_v_o),
    .itlb_clear_o(itlb_clear_o), .dtlb_clear_o(dtlb_clear_o),
    .busy_o(busy_o),
    .itlb_walk_count_o(itlb_walk_count_o), .dtlb_walk_count_o(dtlb_walk_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    flush_i = 0; itlb_miss_v_i = 0; dtlb_miss_v_i = 0;
    ptw_req_ready_i = 0; ptw_resp_v_i = 0; ptw_resp_fault_i = 0;
    step();
    reset_n_i = 1'b1;
  endtask

  // Full ITLB walk from IDLE back to IDLE, response the cycle after issue.
  task automatic walk_i(input logic [VW-1:0] vt, input logic [EW-1:0] ent);
    itlb_miss_v_i = 1; itlb_miss_vtag_i = vt;
    step();
    itlb_miss_v_i = 0; ptw_req_ready_i = 1;
    step();
    ptw_req_ready_i = 0; ptw_resp_v_i = 1; ptw_resp_entry_i = ent; ptw_resp_fault_i = 0;
    step();
    ptw_resp_v_i = 0;
    step();
  endtask

  initial begin
    itlb_miss_vtag_i = '0; dtlb_miss_vtag_i = '0; ptw_resp_entry_i = '0;
    do_reset();
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_req_v", ptw_req_v_o, 0);
    chk("rst_icnt", itlb_walk_count_o, 0);
    chk("rst_dcnt", dtlb_walk_count_o, 0);
    chk("rst_clear", itlb_clear_o, 0);

    // Single ITLB walk.
    itlb_miss_v_i = 1; itlb_miss_vtag_i = 'h1234;
    #1;
    chk("t1_iyumi", itlb_miss_yumi_o, 1);
    chk("t1_dyumi", dtlb_miss_yumi_o, 0);
    step();
    itlb_miss_v_i = 0; ptw_req_ready_i = 1;
    #1;
    chk("t1_req_v", ptw_req_v_o, 1);
    chk("t1_req_vtag", ptw_req_vtag_o, 'h1234);
    chk("t1_req_src", ptw_req_src_o, 0);
    chk("t1_icnt", itlb_walk_count_o, 1);
    step();
    ptw_req_ready_i = 0;
    chk("t1_wait_req_v", ptw_req_v_o, 0);
    chk("t1_wait_busy", busy_o, 1);
    step();
    ptw_resp_v_i = 1; ptw_resp_entry_i = 'hABC;
    step();
    ptw_resp_v_i = 0;
    chk("t1_ifill", itlb_fill_v_o, 1);
    chk("t1_dfill", dtlb_fill_v_o, 0);
    chk("t1_ifault", itlb_fault_v_o, 0);
    chk("t1_fill_vtag", fill_vtag_o, 'h1234);
    chk("t1_fill_entry", fill_entry_o, 'hABC);
    step();
    chk("t1_ifill_off", itlb_fill_v_o, 0);
    chk("t1_idle", busy_o, 0);

    // Both sources held: alternating grants starting with ITLB.
    do_reset();
    itlb_miss_v_i = 1; itlb_miss_vtag_i = 'h100;
    dtlb_miss_v_i = 1; dtlb_miss_vtag_i = 'h200;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_iyumi", k), itlb_miss_yumi_o, (k % 2 == 0));
      chk($sformatf("rr%0d_dyumi", k), dtlb_miss_yumi_o, (k % 2 == 1));
      step();
      chk($sformatf("rr%0d_src", k), ptw_req_src_o, (k % 2 == 1));
      chk($sformatf("rr%0d_vtag", k), ptw_req_vtag_o, (k % 2 == 1) ? 'h200 : 'h100);
      chk($sformatf("rr%0d_yumi_busy", k), itlb_miss_yumi_o | dtlb_miss_yumi_o, 0);
      ptw_req_ready_i = 1;
      step();
      ptw_req_ready_i = 0; ptw_resp_v_i = 1; ptw_resp_entry_i = 34'(k + 5);
      step();
      ptw_resp_v_i = 0;
      chk($sformatf("rr%0d_ifill", k), itlb_fill_v_o, (k % 2 == 0));
      chk($sformatf("rr%0d_dfill", k), dtlb_fill_v_o, (k % 2 == 1));
      chk($sformatf("rr%0d_entry", k), fill_entry_o, k + 5);
      step();
    end
    itlb_miss_v_i = 0; dtlb_miss_v_i = 0;
    chk("rr_icnt", itlb_walk_count_o, 2);
    chk("rr_dcnt", dtlb_walk_count_o, 2);

    // DTLB walk ending in a page fault.
    do_reset();
    dtlb_miss_v_i = 1; dtlb_miss_vtag_i = 'h55;
    #1;
    chk("f_dyumi", dtlb_miss_yumi_o, 1);
    step();
    dtlb_miss_v_i = 0; ptw_req_ready_i = 1;
    step();
    ptw_req_ready_i = 0; ptw_resp_v_i = 1; ptw_resp_fault_i = 1;
    step();
    ptw_resp_v_i = 0; ptw_resp_fault_i = 0;
    chk("f_dfault", dtlb_fault_v_o, 1);
    chk("f_dfill", dtlb_fill_v_o, 0);
    chk("f_iany", {itlb_fill_v_o, itlb_fault_v_o}, 0);
    step();
    chk("f_dfault_off", dtlb_fault_v_o, 0);

    // Flush in WAIT: response three cycles later is discarded.
    do_reset();
    itlb_miss_v_i = 1; itlb_miss_vtag_i = 'h77;
    step();
    itlb_miss_v_i = 0; ptw_req_ready_i = 1;
    step();
    ptw_req_ready_i = 0; flush_i = 1;
    step();
    flush_i = 0;
    chk("fw_iclear", itlb_clear_o, 1);
    chk("fw_dclear", dtlb_clear_o, 1);
    chk("fw_busy", busy_o, 1);
    step();
    chk("fw_clear_off", itlb_clear_o, 0);
    step();
    ptw_resp_v_i = 1; ptw_resp_entry_i = 'h999;
    step();
    ptw_resp_v_i = 0;
    chk("fw_nofill", {itlb_fill_v_o, dtlb_fill_v_o, itlb_fault_v_o, dtlb_fault_v_o}, 0);
    chk("fw_busy_off", busy_o, 0);

    // Flush in REQ: request withdrawn, held miss re-granted after flush.
    do_reset();
    itlb_miss_v_i = 1; itlb_miss_vtag_i = 'h31;
    step();
    flush_i = 1;
    step();
    chk("fr_req_v", ptw_req_v_o, 0);
    chk("fr_busy", busy_o, 0);
    chk("fr_clear", itlb_clear_o, 1);
    chk("fr_blocked", itlb_miss_yumi_o, 0);
    step();
    flush_i = 0;
    #1;
    chk("fr_regrant", itlb_miss_yumi_o, 1);
    step();
    itlb_miss_v_i = 0;
    chk("fr_req_v2", ptw_req_v_o, 1);
    chk("fr_icnt", itlb_walk_count_o, 2);

    // Saturation, then async reset in the middle of a walk.
    do_reset();
    for (int k = 0; k < 5; k++) walk_i(27'(k), 34'(k));
    chk("sat_icnt", itlb_walk_count_o, 3);
    itlb_miss_v_i = 1;
    step();
    itlb_miss_v_i = 0; ptw_req_ready_i = 1;
    step();
    ptw_req_ready_i = 0;
    chk("mid_busy", busy_o, 1);
    reset_n_i = 0;
    #1;
    chk("ar_busy", busy_o, 0);
    chk("ar_icnt", itlb_walk_count_o, 0);
    step();
    reset_n_i = 1; ptw_resp_v_i = 1;
    step();
    ptw_resp_v_i = 0;
    chk("ar_stray_resp", itlb_fill_v_o, 0);
    chk("ar_stray_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_tlb_miss_arbiter.md
Name: bp_tlb_miss_arbiter

Overview:
Shares one page-table walker (PTW) between the ITLB and DTLB miss paths. It accepts one miss at a time using round-robin arbitration and sequences the walk request/response handshake. It then routes the resulting fill or page fault back to the originating TLB. It converts fence/flush requests into TLB clear pulses and counts walks per source. It sits between the FE/BE TLBs and the shared PTW.

Parameters:
vtag_width_p, 27, virtual tag width
ptag_width_p, 28, physical tag width (informational; carried inside entry)
entry_width_p, 34, width of the packed leaf PTE entry written into a TLB
count_width_p, 16, width of per-source walk counters (saturating)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; one clock; asynchronous, active-low
flush_i  in  1  sfence/satp-change request; kills in-flight walk, clears both TLBs
itlb_miss_v_i  in  1  ITLB miss pending
itlb_miss_vtag_i  in  vtag_width_p  ITLB miss vtag
itlb_miss_yumi_o  out  1  ITLB miss accepted this cycle
dtlb_miss_v_i  in  1  DTLB miss pending
dtlb_miss_vtag_i  in  vtag_width_p  DTLB miss vtag
dtlb_miss_yumi_o  out  1  DTLB miss accepted this cycle
ptw_req_v_o  out  1  walk request valid
ptw_req_vtag_o  out  vtag_width_p  vtag to walk
ptw_req_src_o  out  1  0=ITLB, 1=DTLB
ptw_req_ready_i  in  1  PTW accepts request
ptw_resp_v_i  in  1  walk complete (one-cycle pulse)
ptw_resp_fault_i  in  1  walk ended in page fault
ptw_resp_entry_i  in  entry_width_p  leaf entry
fill_vtag_o  out  vtag_width_p  fill vtag (shared by both TLBs)
fill_entry_o  out  entry_width_p  fill entry (shared)
itlb_fill_v_o / dtlb_fill_v_o  out  1 each  write fill into that TLB
itlb_fault_v_o / dtlb_fault_v_o  out  1 each  page fault for that source
itlb_clear_o / dtlb_clear_o  out  1 each  clear TLB
busy_o  out  1  state != IDLE
itlb_walk_count_o / dtlb_walk_count_o  out  count_width_p each  grants per source

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset: IDLE, prio_r=0 (ITLB favoured), kill_r=0, counters=0, all outputs 0.
- IDLE, no flush_i, any miss_v:
  - Grant by round-robin: sole requester wins; on a tie, the source named by prio_r wins.
  - Assert that source's yumi combinationally this cycle.
  - Latch vtag and src; set prio_r = ~src; increment that counter, saturating at 2^count_width_p-1; go to REQ.
  - flush_i in IDLE blocks the grant.
- REQ: ptw_req_v_o=1 with latched vtag/src. On ptw_req_ready_i, go to WAIT. On flush_i (even together with ready), the request is withdrawn, no walk is issued, and the state returns to IDLE.
- WAIT: flush_i sets kill_r. On ptw_resp_v_i:
  - if kill_r or flush_i that cycle: discard and go to IDLE.
  - otherwise: register entry and fault, then go to RESP.
- RESP (exactly one cycle):
  - fill_vtag_o/fill_entry_o driven from the registers.
  - {src}_fill_v_o=1 if no fault; {src}_fault_v_o=1 if fault. Never both, never for the other source.
  - Then go to IDLE; kill_r cleared.
- fill_vtag_o/fill_entry_o hold their last value outside RESP (don't-care when fill_v=0).
- Clear: itlb_clear_o and dtlb_clear_o are registered copies of flush_i, asserted the cycle after each flush_i cycle. A flush in RESP does not suppress the fill; the clear follows one cycle later and wins.
- Latency: miss_v in IDLE → ptw_req_v_o next cycle. ptw_resp_v_i at cycle k → fill/fault at k+1. The next grant is possible no earlier than the cycle after RESP.
- Only one walk outstanding. A ptw_resp_v_i outside WAIT is ignored.
- reset_n_i low mid-walk: immediate return to reset values. Any PTW response after reset is ignored unless in WAIT.
- Requesters hold miss_v/vtag until yumi; the block never reads vtag except in the grant cycle.

Test Plan:
- Single ITLB miss vtag=0x1234, ready=1, response entry=0xABC two cycles later → yumi cycle 0, ptw_req_v cycle 1, itlb_fill_v=1 with vtag 0x1234/entry 0xABC at response+1; itlb_walk_count=1.
- Both misses held continuously for 4 walks → grant order I,D,I,D; counts 2/2; no fill to the wrong TLB.
- DTLB walk with fault=1 → dtlb_fault_v=1 for one cycle, dtlb_fill_v=0, itlb_* all 0.
- flush_i in WAIT, response 3 cycles later → no fill, no fault; itlb_clear/dtlb_clear high one cycle after flush; busy_o drops after the response.
- flush_i during REQ with ready_i=0 → ptw_req_v drops next cycle, state IDLE, clears pulse; a held miss is re-granted after flush deasserts.
- Counter saturation (count_width_p=2): 5 ITLB walks → itlb_walk_count_o=3; reset_n_i low mid-WAIT → busy_o=0 and counts=0 immediately.
